// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: round-robin grant,
// one operation in flight, result held on a per-requester valid/ready response channel.
module alu_arbiter #(
   parameter int WIDTH    = 8,
   parameter int OP_WIDTH = 3
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [OP_WIDTH-1:0] req0_op,
   input  logic [WIDTH-1:0]    req0_a,
   input  logic [WIDTH-1:0]    req0_b,

   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [OP_WIDTH-1:0] req1_op,
   input  logic [WIDTH-1:0]    req1_a,
   input  logic [WIDTH-1:0]    req1_b,

   output logic                rsp0_valid,
   input  logic                rsp0_ready,
   output logic [WIDTH:0]      rsp0_data,
   output logic                rsp0_zero,

   output logic                rsp1_valid,
   input  logic                rsp1_ready,
   output logic [WIDTH:0]      rsp1_data,
   output logic                rsp1_zero,

   output logic [OP_WIDTH-1:0] alu_op,
   output logic [WIDTH-1:0]    alu_op1,
   output logic [WIDTH-1:0]    alu_op2,
   input  logic [WIDTH:0]      alu_out,

   output logic                busy,
   output logic [1:0]          state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // The requester keeps its payload stable while valid is high and ready is low;
   // the arbiter keeps response data/valid stable while the response ready is low.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [OP_WIDTH-1:0] op_q;
   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    b_q;
   logic [WIDTH:0]      result_q;
   logic                zero_q;
   logic                owner_q;
   logic                last_grant_q;

   logic                grant_valid;
   logic                grant;
   logic                accept;
   logic                rsp_fire;

   // A tie goes to the requester not served last; a lone request always wins.
   always_comb begin
      grant_valid = 1'b0;
      grant       = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_valid = 1'b1;
         grant       = ~last_grant_q;
      end else if (req0_valid) begin
         grant_valid = 1'b1;
         grant       = 1'b0;
      end else if (req1_valid) begin
         grant_valid = 1'b1;
         grant       = 1'b1;
      end
   end

   assign accept   = (state == IDLE) && grant_valid;
   assign rsp_fire = (state == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = accept && !grant;
      req1_ready = accept && grant;
      rsp0_valid = (state == RESP) && !owner_q;
      rsp1_valid = (state == RESP) && owner_q;
      alu_op     = (state == EXEC) ? op_q : '0;
      busy       = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         zero_q       <= 1'b0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         if (accept) begin
            op_q    <= grant ? req1_op : req0_op;
            a_q     <= grant ? req1_a  : req0_a;
            b_q     <= grant ? req1_b  : req0_b;
            owner_q <= grant;
         end
         if (state == EXEC) begin
            result_q <= alu_out;
            zero_q   <= (alu_out[WIDTH-1:0] == '0);
         end
         // The pointer moves only once the owner has taken its result.
         if (rsp_fire) begin
            last_grant_q <= owner_q;
         end
      end
   end

   assign alu_op1   = a_q;
   assign alu_op2   = b_q;
   assign rsp0_data = result_q;
   assign rsp1_data = result_q;
   assign rsp0_zero = zero_q;
   assign rsp1_zero = zero_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed plan steps then random traffic, checked against a
// transaction-level model of grant order, 2-cycle latency and ALU arithmetic.
module tb_alu_arbiter;

   localparam int W   = 8;
   localparam int OPW = 3;

   logic           clk;
   logic           rst_n;
   logic           req0_valid, req0_ready, req1_valid, req1_ready;
   logic [OPW-1:0] req0_op, req1_op;
   logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic           rsp0_valid, rsp0_ready, rsp0_zero;
   logic           rsp1_valid, rsp1_ready, rsp1_zero;
   logic [W:0]     rsp0_data, rsp1_data;
   logic [OPW-1:0] alu_op;
   logic [W-1:0]   alu_op1, alu_op2;
   logic [W:0]     alu_out;
   logic           busy;
   logic [1:0]     state_dbg;

   int errors = 0;
   int checks = 0;
   bit m_last;   // model: requester served last

   alu_arbiter #(.WIDTH(W), .OP_WIDTH(OPW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp0_zero(rsp0_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .rsp1_zero(rsp1_zero),
      .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_out(alu_out),
      .busy(busy), .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W:0] ref_alu(input logic [OPW-1:0] op,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] r;
      case (op)
         3'd1:    r = {1'b0, a} + {1'b0, b};
         3'd2:    r = {1'b0, a} - {1'b0, b};
         3'd3:    r = {1'b0, a & b};
         3'd4:    r = {1'b0, a | b};
         3'd5:    r = {1'b0, a ^ b};
         default: r = '0;
      endcase
      return r;
   endfunction

   // external ALU stub
   always_comb alu_out = ref_alu(alu_op, alu_op1, alu_op2);

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values();
      chk("rst_busy", busy, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp0_data", rsp0_data, 0);
      chk("rst_rsp1_data", rsp1_data, 0);
      chk("rst_rsp0_zero", rsp0_zero, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_alu_op1", alu_op1, 0);
      chk("rst_alu_op2", alu_op2, 0);
   endtask

   // Driver + scoreboard for one transaction. Entered just after a rising edge with
   // the DUT idle and the request valids already set by the caller.
   task automatic run_txn(input int stall, input bit use_want, input logic [W:0] want);
      bit             w;
      logic [OPW-1:0] eop;
      logic [W-1:0]   ea, eb;
      logic [W:0]     exp_q[$];
      logic [W:0]     eres;
      w   = (req0_valid && req1_valid) ? !m_last : req1_valid;
      eop = w ? req1_op : req0_op;
      ea  = w ? req1_a  : req0_a;
      eb  = w ? req1_b  : req0_b;
      exp_q.push_back(ref_alu(eop, ea, eb));
      #1;
      chk("idle_busy", busy, 0);
      chk("grant_req0_ready", req0_ready, !w);
      chk("grant_req1_ready", req1_ready, w);
      @(posedge clk); #1;
      if (w) req1_valid = 1'b0; else req0_valid = 1'b0;
      chk("exec_busy", busy, 1);
      chk("exec_alu_op", alu_op, eop);
      chk("exec_alu_op1", alu_op1, ea);
      chk("exec_alu_op2", alu_op2, eb);
      chk("exec_req_ready", {req1_ready, req0_ready}, 0);
      chk("exec_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
      @(posedge clk); #1;
      eres = exp_q.pop_front();
      if (use_want) chk("plan_data", w ? rsp1_data : rsp0_data, want);
      for (int i = 0; i <= stall; i++) begin
         if (w) begin
            rsp1_ready = (i == stall);
            rsp0_ready = 1'($urandom_range(0, 1));
         end else begin
            rsp0_ready = (i == stall);
            rsp1_ready = 1'($urandom_range(0, 1));
         end
         chk("resp_rsp0_valid", rsp0_valid, !w);
         chk("resp_rsp1_valid", rsp1_valid, w);
         chk("resp_data", w ? rsp1_data : rsp0_data, eres);
         chk("resp_data_other", w ? rsp0_data : rsp1_data, eres);
         chk("resp_zero", w ? rsp1_zero : rsp0_zero, eres[W-1:0] == 0);
         chk("resp_alu_op_idle", alu_op, 0);
         chk("resp_alu_op1_hold", alu_op1, ea);
         chk("resp_req_ready", {req1_ready, req0_ready}, 0);
         @(posedge clk); #1;
      end
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      m_last = w;
      chk("done_busy", busy, 0);
      chk("done_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
   endtask

   task automatic set_req(input bit port, input logic [OPW-1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      if (port) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      rsp0_ready = 0; rsp1_ready = 0;
      m_last = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_values();
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_req_ready", {req1_ready, req0_ready}, 0);

      // port0 add with carry out
      set_req(0, 3'b001, 8'hFF, 8'h01);
      run_txn(0, 1, 9'h100);
      // port1 subtract with borrow, then AND to zero
      set_req(1, 3'b010, 8'h05, 8'h07);
      run_txn(0, 1, 9'h1FE);
      set_req(1, 3'b011, 8'hF0, 8'h0F);
      run_txn(0, 1, 9'h000);
      // unused opcode passes through, ALU yields zero
      set_req(0, 3'b111, 8'h12, 8'h34);
      run_txn(0, 1, 9'h000);

      // both requesters continuously valid: strict alternation
      for (int t = 0; t < 4; t++) begin
         if (!req0_valid) set_req(0, 3'b001, 8'(t), 8'h10);
         if (!req1_valid) set_req(1, 3'b101, 8'(t), 8'hA5);
         run_txn(0, 0, '0);
      end
      req0_valid = 0; req1_valid = 0;

      // backpressure: result held 5 cycles while the other requester waits
      set_req(0, 3'b100, 8'h0F, 8'h30);
      set_req(1, 3'b001, 8'h01, 8'h02);
      run_txn(5, 0, '0);
      run_txn(0, 0, '0);
      req0_valid = 0; req1_valid = 0;

      // reset during EXEC: in-flight op dropped, pointer back to favouring requester 0
      set_req(1, 3'b001, 8'h22, 8'h33);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      chk("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_values();
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("post_reset_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
         @(posedge clk); #1;
      end
      set_req(0, 3'b010, 8'h40, 8'h01);
      set_req(1, 3'b010, 8'h50, 8'h01);
      run_txn(0, 1, 9'h03F);
      req1_valid = 0;

      // random traffic
      for (int t = 0; t < 40; t++) begin
         if (!req0_valid && $urandom_range(0, 2) != 0)
            set_req(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         if (!req1_valid && $urandom_range(0, 2) != 0)
            set_req(1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         if (!req0_valid && !req1_valid)
            set_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         run_txn(int'($urandom_range(0, 3)), 0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
